filt_sched_controller: RTL and testbench
========================================

# filt_sched_controller

Read-side scheduler for the filter scratchpad. Once the filter loader reports the scratchpad filled (`filt_ready`), this block generates the sequence of scratchpad read addresses the PE consumes. It walks every tap of a filter once per output window, repeats for `win_count` windows, then advances to the next filter stored contiguously (circularly) in the scratchpad. It sits between the filter-loader's `filt_ready` and the PE's address-consuming port, using a valid/ready handshake.

## Interface
- `ADDR_LEN`, 4, scratchpad address width
- `SCRATCH_DEPTH`, 16, scratchpad entries; must be ≤ 2^ADDR_LEN
- `CNT_LEN`, 8, width of the window counter
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  run request; sampled only in IDLE
- `filt_len`  in  ADDR_LEN  taps per filter; captured at start
- `filt_count`  in  ADDR_LEN  filters to process; captured at start
- `win_count`  in  CNT_LEN  windows per filter; captured at start
- `filt_ready`  in  1  scratchpad loaded (from loader)
- `pe_ready`  in  1  consumer accepts address this cycle
- `raddr_valid`  out  1  `filt_raddr` is valid
- `filt_raddr`  out  ADDR_LEN  scratchpad read address
- `last_tap`  out  1  current address is the final tap of a window
- `last_window`  out  1  current address belongs to the final window of a filter
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle run-complete pulse

## Operation
- States: IDLE, WAIT_LOAD, ISSUE, DONE.
- IDLE → WAIT_LOAD on `start`, capturing the config registers and clearing `tap`, `win`, `filt` and `base`.
  - If any captured value (`filt_len`, `filt_count`, `win_count`) is 0, IDLE → DONE instead; no addresses are issued.
- WAIT_LOAD → ISSUE when `filt_ready` = 1.
- ISSUE: `raddr_valid` = 1 and `filt_raddr` = (`base` + `tap`) mod SCRATCH_DEPTH.
  - The sum is computed at ADDR_LEN+1 bits, then SCRATCH_DEPTH is subtracted if the sum is ≥ SCRATCH_DEPTH.
- A transfer is `raddr_valid` & `pe_ready`. On each transfer:
  - If `tap` < `filt_len`−1: `tap`++.
  - Else `tap` ← 0, and if `win` < `win_count`−1: `win`++.
  - Else `win` ← 0, and if `filt` < `filt_count`−1: `filt`++ and `base` ← (`base` + `filt_len`) mod SCRATCH_DEPTH, using the same wrap rule.
  - Else go to DONE.
- Moving to the next filter or window costs no bubble cycles.
- Without a transfer (`pe_ready` = 0), `filt_raddr`, `last_tap` and `last_window` hold stable.
- `last_tap` = ISSUE & (`tap` == `filt_len`−1).
- `last_window` = ISSUE & (`win` == `win_count`−1).
- DONE: `done` = 1 for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored. Input config changes after capture are ignored.
- `rst` in any state → IDLE at the next edge; all counters and `base` are cleared.

## Timing
- Reset values: `raddr_valid`=0, `filt_raddr`=0, `last_tap`=0, `last_window`=0, `busy`=0, `done`=0.
- All outputs decode combinationally from state and counter registers; there are no input-to-output combinational paths except through `pe_ready` affecting the next state.
- `start` high in cycle 0 → WAIT_LOAD in cycle 1.
  - If `filt_ready` is already 1, the first valid address appears in cycle 2.
- With `pe_ready` held at 1, the run uses exactly `filt_len`·`win_count`·`filt_count` ISSUE cycles, followed by one DONE cycle.
- Zero-config start: `done` = 1 in cycle 1 and `busy` = 1 only in that cycle.
- `start` may be asserted in the cycle after DONE (state is IDLE).

## Configuration
- `FILT_SCHED_STALL_CNT_EN` defined:
  - Adds an output `stall_cnt` [15:0].
  - It increments in every cycle with `raddr_valid` & ~`pe_ready` and saturates at 16'hFFFF.
  - It clears on `rst` and when a `start` is accepted.
- Not defined: the port and its counter are absent, and behaviour is otherwise identical.

## Test plan
- Basic sequence: SCRATCH_DEPTH=16, `filt_len`=3, `win_count`=2, `filt_count`=2, `pe_ready`=1, `filt_ready`=1 → addresses 0,1,2,0,1,2,3,4,5,3,4,5.
  - `last_tap` on the 3rd/6th/9th/12th addresses; `done` 1 cycle after the 12th.
- Wrap: `filt_len`=5, `win_count`=1, `filt_count`=4 → bases 0,5,10,15; the 4th filter issues 15,0,1,2,3.
- Stall: same config as the basic sequence, `pe_ready` low for 3 cycles while address 4 is presented → address 4 held for 4 cycles, no skipped or duplicated addresses.
  - With `FILT_SCHED_STALL_CNT_EN`, `stall_cnt`=3.
- Load wait / zero config: `filt_ready` held low for 5 cycles after start → `raddr_valid` stays 0, `busy` = 1.
  - Separately, `win_count`=0 → `done` in cycle 1 and no `raddr_valid`.
- Reset mid-run: assert `rst` during the 7th transfer → next cycle IDLE, all outputs at reset values.
  - A new `start` then restarts from address 0.

Source files
------------

// File: rtl/filt_sched_controller.sv
// filt_sched_controller: read-address scheduler for the filter scratchpad.
// After the loader reports the scratchpad filled, walks every tap of a filter
// once per window, repeats for win_count windows, then moves to the next
// filter stored contiguously (circularly) in the scratchpad.
// Optional feature macro: FILT_SCHED_STALL_CNT_EN adds a saturating 16-bit
// stall_cnt output counting cycles where an address is offered but not taken.
module filt_sched_controller #(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int CNT_LEN       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] filt_len,
  input  logic [ADDR_LEN-1:0] filt_count,
  input  logic [CNT_LEN-1:0]  win_count,
  input  logic                filt_ready,
  input  logic                pe_ready,
  output logic                raddr_valid,
  output logic [ADDR_LEN-1:0] filt_raddr,
  output logic                last_tap,
  output logic                last_window,
  output logic                busy,
  output logic                done
`ifdef FILT_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    ISSUE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [ADDR_LEN:0]   DEPTH_W = (ADDR_LEN+1)'(SCRATCH_DEPTH);
  localparam logic [ADDR_LEN-1:0] ONE_A   = ADDR_LEN'(1);
  localparam logic [CNT_LEN-1:0]  ONE_C   = CNT_LEN'(1);

  state_t              state_reg;
  logic [ADDR_LEN-1:0] len_reg;
  logic [ADDR_LEN-1:0] fcnt_reg;
  logic [CNT_LEN-1:0]  wcnt_reg;
  logic [ADDR_LEN-1:0] tap_reg;
  logic [CNT_LEN-1:0]  win_reg;
  logic [ADDR_LEN-1:0] filt_reg;
  logic [ADDR_LEN-1:0] base_reg;

  // Modular add for two in-range scratchpad offsets: one conditional subtract suffices.
  function automatic logic [ADDR_LEN-1:0] wrap_add(input logic [ADDR_LEN-1:0] a,
                                                   input logic [ADDR_LEN-1:0] b);
    logic [ADDR_LEN:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= DEPTH_W) sum = sum - DEPTH_W;
    return sum[ADDR_LEN-1:0];
  endfunction

  // Control FSM plus tap/window/filter counters and the running filter base.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      fcnt_reg  <= '0;
      wcnt_reg  <= '0;
      tap_reg   <= '0;
      win_reg   <= '0;
      filt_reg  <= '0;
      base_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg  <= filt_len;
            fcnt_reg <= filt_count;
            wcnt_reg <= win_count;
            tap_reg  <= '0;
            win_reg  <= '0;
            filt_reg <= '0;
            base_reg <= '0;
            // A zero-sized job completes without touching the scratchpad.
            if (filt_len == '0 || filt_count == '0 || win_count == '0)
              state_reg <= DONE;
            else
              state_reg <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          if (filt_ready) state_reg <= ISSUE;
        end
        ISSUE: begin
          if (pe_ready) begin
            if (tap_reg != len_reg - ONE_A) begin
              tap_reg <= tap_reg + ONE_A;
            end else begin
              tap_reg <= '0;
              if (win_reg != wcnt_reg - ONE_C) begin
                win_reg <= win_reg + ONE_C;
              end else begin
                win_reg <= '0;
                if (filt_reg != fcnt_reg - ONE_A) begin
                  filt_reg <= filt_reg + ONE_A;
                  base_reg <= wrap_add(base_reg, len_reg);
                end else begin
                  state_reg <= DONE;
                end
              end
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode from state and counters only; address is gated to 0 outside ISSUE.
  always_comb begin
    raddr_valid = (state_reg == ISSUE);
    filt_raddr  = raddr_valid ? wrap_add(base_reg, tap_reg) : '0;
    last_tap    = raddr_valid && (tap_reg == len_reg - ONE_A);
    last_window = raddr_valid && (win_reg == wcnt_reg - ONE_C);
    busy        = (state_reg != IDLE);
    done        = (state_reg == DONE);
  end

`ifdef FILT_SCHED_STALL_CNT_EN
  logic [15:0] stall_reg;

  // Saturating count of offered-but-not-accepted cycles, cleared per run.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      stall_reg <= '0;
    end else if (raddr_valid && !pe_ready && stall_reg != 16'hFFFF) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_reg;
`endif

endmodule

// File: tb/tb_filt_sched_controller.sv
// Self-checking bench for filt_sched_controller: a table of configurations
// with hand-computed totals, hand-written basic/stall/load-wait/reset
// sequences, and randomized runs checked against an address-list model.
module tb_filt_sched_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] filt_len;
  logic [3:0] filt_count;
  logic [7:0] win_count;
  logic       filt_ready;
  logic       pe_ready;
  logic       raddr_valid;
  logic [3:0] filt_raddr;
  logic       last_tap;
  logic       last_window;
  logic       busy;
  logic       done;
`ifdef FILT_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  filt_sched_controller #(.ADDR_LEN(4), .SCRATCH_DEPTH(16), .CNT_LEN(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .filt_len    (filt_len),
    .filt_count  (filt_count),
    .win_count   (win_count),
    .filt_ready  (filt_ready),
    .pe_ready    (pe_ready),
    .raddr_valid (raddr_valid),
    .filt_raddr  (filt_raddr),
    .last_tap    (last_tap),
    .last_window (last_window),
    .busy        (busy),
    .done        (done)
`ifdef FILT_SCHED_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int  addr;
    bit  lt;
    bit  lw;
  } xfer_t;

  typedef struct {
    int len;
    int fc;
    int wc;
    int delay;
    int exp_total;
    int exp_last;
  } vec_t;

  xfer_t exp_q[$];
  int    got_addr[$];
  bit    got_lt[$];
  int    n_valid, first_valid, done_cyc, n_stall, n_addr4;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, int'(raddr_valid), 0);
    chk({tag, "_raddr"}, int'(filt_raddr), 0);
    chk({tag, "_last_tap"}, int'(last_tap), 0);
    chk({tag, "_last_win"}, int'(last_window), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // mode 0: pe_ready always 1; mode 1: random pe_ready; mode 2: 3-cycle stall
  // on the first presentation of address 4.
  task automatic run_and_check(input int len, input int fc, input int wc,
                               input int mode, input int load_delay, input string tag);
    int cyc, budget, stall_left, total, exp_first;
    bit zero, prev_hold, stalled_once, prev_lt, prev_lw;
    int prev_addr;
    xfer_t x;
    exp_q.delete();
    got_addr.delete();
    got_lt.delete();
    // Reference: filter f occupies slots f*len .. f*len+len-1 modulo 16.
    for (int f = 0; f < fc; f++)
      for (int w = 0; w < wc; w++)
        for (int t = 0; t < len; t++) begin
          x.addr = (f * len + t) % 16;
          x.lt   = (t == len - 1);
          x.lw   = (w == wc - 1);
          exp_q.push_back(x);
        end
    total = len * fc * wc;
    zero  = (total == 0);
    n_valid = 0; first_valid = -1; done_cyc = -1; n_stall = 0; n_addr4 = 0;
    prev_hold = 0; prev_addr = 0; prev_lt = 0; prev_lw = 0;
    stall_left = 0; stalled_once = 0;
    filt_len   = 4'(len);
    filt_count = 4'(fc);
    win_count  = 8'(wc);
    filt_ready = (load_delay == 0);
    pe_ready   = 1'b0;
    start      = 1'b1;
    budget = 4 * total + 20 + load_delay;
    cyc = 0;
    while (1) begin
      step();
      cyc++;
      // Config changes and stray starts after capture must be ignored.
      filt_len   = 4'($urandom);
      filt_count = 4'($urandom);
      win_count  = 8'($urandom);
      start      = 1'($urandom_range(0, 1));
      if (cyc >= load_delay) filt_ready = 1'b1;
      if (prev_hold) begin
        chk({tag, "_hold_valid"}, int'(raddr_valid), 1);
        chk({tag, "_hold_addr"}, int'(filt_raddr), prev_addr);
        chk({tag, "_hold_lt"}, int'(last_tap), int'(prev_lt));
        chk({tag, "_hold_lw"}, int'(last_window), int'(prev_lw));
      end
      if (raddr_valid) begin
        if (first_valid < 0) first_valid = cyc;
        n_valid++;
        if (filt_raddr == 4'd4) n_addr4++;
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_addr"}, int'(filt_raddr), -1);
          break;
        end
        chk({tag, "_addr"}, int'(filt_raddr), exp_q[0].addr);
        chk({tag, "_last_tap"}, int'(last_tap), int'(exp_q[0].lt));
        chk({tag, "_last_win"}, int'(last_window), int'(exp_q[0].lw));
        case (mode)
          0: pe_ready = 1'b1;
          1: pe_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (filt_raddr == 4'd4 && !stalled_once) begin
              stalled_once = 1;
              stall_left = 3;
            end
            pe_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
          end
        endcase
        if (pe_ready) begin
          got_addr.push_back(int'(filt_raddr));
          got_lt.push_back(last_tap);
          void'(exp_q.pop_front());
        end else begin
          n_stall++;
        end
        prev_hold = !pe_ready;
        prev_addr = int'(filt_raddr);
        prev_lt   = last_tap;
        prev_lw   = last_window;
      end else begin
        prev_hold = 0;
        pe_ready  = 1'($urandom_range(0, 1));
        if (!done) chk({tag, "_busy_wait"}, int'(busy), 1);
      end
      if (done) begin
        done_cyc = cyc;
        chk({tag, "_busy_in_done"}, int'(busy), 1);
        chk({tag, "_remaining"}, exp_q.size(), 0);
`ifdef FILT_SCHED_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, int'(stall_cnt), n_stall);
`endif
        break;
      end
      if (cyc > budget) begin
        chk({tag, "_timeout"}, cyc, budget);
        break;
      end
    end
    step();
    start = 1'b0;
    pe_ready = 1'b0;
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_valid_after"}, int'(raddr_valid), 0);
    if (zero) begin
      chk({tag, "_zero_done_cycle"}, done_cyc, 1);
      chk({tag, "_zero_valids"}, n_valid, 0);
    end else begin
      exp_first = (load_delay + 1 > 2) ? load_delay + 1 : 2;
      chk({tag, "_first_valid"}, first_valid, exp_first);
      chk({tag, "_transfers"}, n_valid - n_stall, total);
      chk({tag, "_done_cycle"}, done_cyc, first_valid + n_valid);
    end
    $display("run %s: len=%0d fc=%0d wc=%0d xfers=%0d stalls=%0d done@%0d",
             tag, len, fc, wc, got_addr.size(), n_stall, done_cyc);
  endtask

  vec_t vecs[9];
  int basic_addr[12];
  bit basic_lt[12];

  initial begin
    int k;
    bit hit;
    rst = 1'b1; start = 1'b0; filt_len = '0; filt_count = '0; win_count = '0;
    filt_ready = 1'b0; pe_ready = 1'b0;

    vecs[0] = '{len: 3,  fc: 2, wc: 2, delay: 0, exp_total: 12, exp_last: 5};
    vecs[1] = '{len: 5,  fc: 4, wc: 1, delay: 0, exp_total: 20, exp_last: 3};
    vecs[2] = '{len: 1,  fc: 1, wc: 1, delay: 0, exp_total: 1,  exp_last: 0};
    vecs[3] = '{len: 4,  fc: 1, wc: 0, delay: 0, exp_total: 0,  exp_last: -1};
    vecs[4] = '{len: 0,  fc: 2, wc: 3, delay: 0, exp_total: 0,  exp_last: -1};
    vecs[5] = '{len: 7,  fc: 3, wc: 2, delay: 2, exp_total: 42, exp_last: 4};
    vecs[6] = '{len: 15, fc: 2, wc: 1, delay: 3, exp_total: 30, exp_last: 13};
    vecs[7] = '{len: 2,  fc: 0, wc: 5, delay: 0, exp_total: 0,  exp_last: -1};
    vecs[8] = '{len: 4,  fc: 5, wc: 1, delay: 0, exp_total: 20, exp_last: 3};

    basic_addr = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    basic_lt   = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    repeat (3) step();
    chk_idle_outputs("reset");
`ifdef FILT_SCHED_STALL_CNT_EN
    chk("reset_stall_cnt", int'(stall_cnt), 0);
`endif
    rst = 1'b0;

    // Table of configurations with hand-computed totals and final addresses.
    for (int i = 0; i < 9; i++) begin
      run_and_check(vecs[i].len, vecs[i].fc, vecs[i].wc, 0, vecs[i].delay, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_count", i), got_addr.size(), vecs[i].exp_total);
      if (vecs[i].exp_total > 0 && got_addr.size() > 0)
        chk($sformatf("vec%0d_last_addr", i), got_addr[got_addr.size()-1], vecs[i].exp_last);
      if (i == 1 && got_addr.size() == 20) begin
        chk("wrap_base15", got_addr[15], 15);
        chk("wrap_to0", got_addr[16], 0);
        chk("wrap_end", got_addr[19], 3);
      end
    end

    // Basic sequence, explicit address and last_tap list.
    run_and_check(3, 2, 2, 0, 0, "basic");
    chk("basic_count", got_addr.size(), 12);
    for (int i = 0; i < 12 && i < got_addr.size(); i++) begin
      chk($sformatf("basic_addr%0d", i), got_addr[i], basic_addr[i]);
      chk($sformatf("basic_lt%0d", i), int'(got_lt[i]), int'(basic_lt[i]));
    end

    // Stall on address 4 for 3 cycles.
    run_and_check(3, 2, 2, 2, 0, "stall");
    chk("stall_count", got_addr.size(), 12);
    for (int i = 0; i < 12 && i < got_addr.size(); i++)
      chk($sformatf("stall_addr%0d", i), got_addr[i], basic_addr[i]);
    chk("stall_cycles", n_stall, 3);
    chk("stall_addr4_cycles", n_addr4, 5);

    // Long load wait: filt_ready rises at cycle 6.
    run_and_check(3, 2, 2, 0, 6, "loadwait");

    // Reset during the 7th transfer, then restart from address 0.
    filt_len = 4'd3; filt_count = 4'd2; win_count = 8'd2;
    filt_ready = 1'b1; pe_ready = 1'b1; start = 1'b1;
    k = 0;
    hit = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      start = 1'b0;
      if (raddr_valid) begin
        k++;
        if (k == 7) begin
          chk("rstmid_addr7", int'(filt_raddr), 3);
          rst = 1'b1;
          step();
          chk_idle_outputs("rstmid");
          rst = 1'b0;
          hit = 1;
          break;
        end
      end
    end
    chk("rstmid_reached", int'(hit), 1);
    step();
    chk_idle_outputs("rstmid_idle");
    run_and_check(3, 2, 2, 0, 0, "after_rst");
    if (got_addr.size() > 0) chk("after_rst_first", got_addr[0], 0);

    // Randomized configurations and backpressure against the address-list model.
    for (int r = 0; r < 40; r++) begin
      run_and_check($urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 4),
                    1, $urandom_range(0, 4), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
